// File: rtl/ccc_clken_gen.sv
// Multi-channel clock-enable generator: PLL-lock settle sequencer, per-channel programmable divide/phase enables,
// all-channel alignment marker and lock-loss reporting. Optional loss counter: define CCC_CLKEN_LOSS_CNT_EN.
module ccc_clken_gen #(
    parameter int NUM_CH        = 4,
    parameter int DIV_W         = 7,
    parameter int DIV_DEFAULT   = 12,
    parameter int PHASE_DEFAULT = 0,
    parameter int LOCK_SETTLE   = 256
) (
    input  logic                      CLK,
    input  logic                      ARST_N,
    input  logic                      PLL_LOCK,
    input  logic                      CFG_LOAD,
    input  logic [NUM_CH*DIV_W-1:0]   DIV_VAL,
    input  logic [NUM_CH*DIV_W-1:0]   PHASE_VAL,
    input  logic                      CLR_LOST,
    output logic [NUM_CH-1:0]         CE,
    output logic                      ALIGN,
    output logic                      READY,
    output logic                      LOCK_LOST,
    output logic [7:0]                LOSS_CNT
);

    localparam int SET_W = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_SETTLE - 1);
    localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] PHASE_RST   = DIV_W'(PHASE_DEFAULT);
    localparam logic [DIV_W-1:0] CNT_ZERO    = {DIV_W{1'b0}};

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [SET_W-1:0]          settle_q, settle_d;
    logic [1:0]                sync_q;
    logic                      lk_s;
    logic                      run_s;
    logic                      loss_evt_s;
    logic                      lock_lost_q;
    logic [NUM_CH*DIV_W-1:0]   div_q;
    logic [NUM_CH*DIV_W-1:0]   phase_q;
    logic [DIV_W-1:0]          cnt_q      [NUM_CH];
    logic [DIV_W-1:0]          cnt_d      [NUM_CH];
    logic [DIV_W:0]            cnt_inc_s  [NUM_CH];
    logic [DIV_W-1:0]          ch_div_s   [NUM_CH];
    logic [DIV_W-1:0]          ch_phase_s [NUM_CH];
    logic [DIV_W-1:0]          ch_peff_s  [NUM_CH];
    logic [NUM_CH-1:0]         ce_s;
    logic                      any_act_s;
    logic                      all_zero_s;

    // Two-flop synchroniser for the raw PLL lock
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], PLL_LOCK};
        end
    end

    assign lk_s       = sync_q[1];
    assign run_s      = (state_q == ST_RUN);
    assign loss_evt_s = run_s && !lk_s;

    // Sequencer state and settle counter registers
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q  <= ST_WAIT_LOCK;
            settle_q <= {SET_W{1'b0}};
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Sequencer next state: any lock drop returns to WAIT_LOCK and restarts the settle window
    always_comb begin
        state_d  = state_q;
        settle_d = {SET_W{1'b0}};
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_SETTLE: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    // Divide/phase shadows capture in every state
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            div_q   <= {NUM_CH{DIV_RST}};
            phase_q <= {NUM_CH{PHASE_RST}};
        end else if (CFG_LOAD) begin
            div_q   <= DIV_VAL;
            phase_q <= PHASE_VAL;
        end else begin
            div_q   <= div_q;
            phase_q <= phase_q;
        end
    end

    // Per-channel field unpack, phase clamp and next count (D=0 and D=1 both pin the count at 0)
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_div_s[i]   = div_q[i*DIV_W +: DIV_W];
            ch_phase_s[i] = phase_q[i*DIV_W +: DIV_W];
            cnt_inc_s[i]  = {1'b0, cnt_q[i]} + {{DIV_W{1'b0}}, 1'b1};
            if (ch_phase_s[i] < ch_div_s[i]) begin
                ch_peff_s[i] = ch_phase_s[i];
            end else begin
                ch_peff_s[i] = CNT_ZERO;
            end
            if (!run_s || CFG_LOAD) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_inc_s[i] >= {1'b0, ch_div_s[i]}) begin
                cnt_d[i] = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_inc_s[i][DIV_W-1:0];
            end
        end
    end

    // Channel counter registers
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Enable decode and alignment; the strobe cycle itself emits no enable
    always_comb begin
        ce_s       = {NUM_CH{1'b0}};
        any_act_s  = 1'b0;
        all_zero_s = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_div_s[i] != CNT_ZERO) begin
                any_act_s = 1'b1;
                ce_s[i]   = run_s && !CFG_LOAD && (cnt_q[i] == ch_peff_s[i]);
                if (cnt_q[i] != CNT_ZERO) begin
                    all_zero_s = 1'b0;
                end else begin
                    all_zero_s = all_zero_s;
                end
            end else begin
                ce_s[i] = 1'b0;
            end
        end
    end

    // Sticky lock-loss flag; a new loss overrides a coincident clear
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            lock_lost_q <= 1'b0;
        end else if (loss_evt_s) begin
            lock_lost_q <= 1'b1;
        end else if (CLR_LOST) begin
            lock_lost_q <= 1'b0;
        end else begin
            lock_lost_q <= lock_lost_q;
        end
    end

`ifdef CCC_CLKEN_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    // Saturating loss-event counter, cleared only by reset
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            loss_cnt_q <= 8'h00;
        end else if (loss_evt_s && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'h01;
        end else begin
            loss_cnt_q <= loss_cnt_q;
        end
    end

    assign LOSS_CNT = loss_cnt_q;
`else
    assign LOSS_CNT = 8'h00;
`endif

    assign CE        = ce_s;
    assign ALIGN     = run_s && any_act_s && all_zero_s;
    assign READY     = run_s;
    assign LOCK_LOST = lock_lost_q;

endmodule

// File: tb/tb_ccc_clken_gen.sv
// Directed bench for ccc_clken_gen: lock sequencing, divide/phase table, lock loss, async reset, loss counter.
module tb_ccc_clken_gen;

`ifdef CCC_CLKEN_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    typedef struct {
        logic        cfg;
        logic [27:0] div;
        logic [27:0] phase;
        logic [3:0]  ce;
        logic        align;
        logic        ready;
    } vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        arst_n, pll_lock, cfg_load, clr_lost;
    logic [27:0] div_val, phase_val;
    logic [3:0]  ce;
    logic        align, ready, lock_lost;
    logic [7:0]  loss_cnt;

    logic        arst2_n, pll2, cfg2, clr2;
    logic [27:0] div2, phase2;
    logic [3:0]  ce2;
    logic        align2, ready2, lost2;
    logic [7:0]  loss_cnt2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n;

    vec_t       tbl [17];
    logic [3:0] ce_exp [17];
    logic [27:0] divs, phs;

    ccc_clken_gen #(.NUM_CH(4), .DIV_W(7), .DIV_DEFAULT(12), .PHASE_DEFAULT(0), .LOCK_SETTLE(256)) dut (
        .CLK(CLK), .ARST_N(arst_n), .PLL_LOCK(pll_lock), .CFG_LOAD(cfg_load),
        .DIV_VAL(div_val), .PHASE_VAL(phase_val), .CLR_LOST(clr_lost),
        .CE(ce), .ALIGN(align), .READY(ready), .LOCK_LOST(lock_lost), .LOSS_CNT(loss_cnt)
    );

    ccc_clken_gen #(.NUM_CH(4), .DIV_W(7), .DIV_DEFAULT(12), .PHASE_DEFAULT(0), .LOCK_SETTLE(2)) dut2 (
        .CLK(CLK), .ARST_N(arst2_n), .PLL_LOCK(pll2), .CFG_LOAD(cfg2),
        .DIV_VAL(div2), .PHASE_VAL(phase2), .CLR_LOST(clr2),
        .CE(ce2), .ALIGN(align2), .READY(ready2), .LOCK_LOST(lost2), .LOSS_CNT(loss_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic tick();
        step();
        #1;
    endtask

    initial begin
        arst_n = 1'b0; pll_lock = 1'b0; cfg_load = 1'b0; clr_lost = 1'b0;
        div_val = 28'd0; phase_val = 28'd0;
        arst2_n = 1'b0; pll2 = 1'b0; cfg2 = 1'b0; clr2 = 1'b0;
        div2 = 28'd0; phase2 = 28'd0;

        divs = {7'd3, 7'd0, 7'd1, 7'd5};
        phs  = {7'd7, 7'd0, 7'd0, 7'd2};
        ce_exp = '{4'h0, 4'hA, 4'h2, 4'h3, 4'hA, 4'h2, 4'h2, 4'hA, 4'h3,
                   4'h2, 4'hA, 4'h2, 4'h2, 4'hB, 4'h2, 4'h2, 4'hA};
        for (int k = 0; k < 17; k++) begin
            tbl[k].cfg   = (k == 0);
            tbl[k].div   = divs;
            tbl[k].phase = phs;
            tbl[k].ce    = ce_exp[k];
            tbl[k].align = (k == 1) || (k == 16);
            tbl[k].ready = 1'b1;
        end

        // Reset state
        #12;
        chk("rst_ready", ready, 1'b0);
        chk("rst_ce", ce, 4'h0);
        chk("rst_align", align, 1'b0);
        chk("rst_lost", lock_lost, 1'b0);
        chk("rst_losscnt", loss_cnt, 8'h00);
        chk("rst2_ready", ready2, 1'b0);
        #6;
        arst_n  = 1'b1;
        arst2_n = 1'b1;
        cyc = 0;

        // Lock at cycle 10 -> READY at 269, defaults 12/0 on all channels
        while (cyc < 281) begin
            step();
            if (cyc == 10) pll_lock = 1'b1;
            #1;
            if (cyc >= 264) begin
                chk("boot_ready", ready, (cyc >= 269));
                chk("boot_ce", ce, (cyc >= 269 && (cyc - 269) % 12 == 0) ? 4'hF : 4'h0);
                chk("boot_align", align, (cyc >= 269 && (cyc - 269) % 12 == 0));
            end
        end

        // Runtime reconfiguration table: strobe at 282, restart at 283
        for (int k = 0; k < 17; k++) begin
            step();
            cfg_load  = tbl[k].cfg;
            div_val   = tbl[k].div;
            phase_val = tbl[k].phase;
            #1;
            chk("tbl_ce", ce, tbl[k].ce);
            chk("tbl_align", align, tbl[k].align);
            chk("tbl_ready", ready, tbl[k].ready);
        end

        // Lock drop in RUN: raw low at 299, outputs low at 302
        step(); pll_lock = 1'b0; #1;
        tick();
        tick();
        chk("drop_ready_hold", ready, 1'b1);
        chk("drop_ce1_hold", ce[1], 1'b1);
        tick();
        chk("drop_ready", ready, 1'b0);
        chk("drop_ce", ce, 4'h0);
        chk("drop_align", align, 1'b0);
        chk("drop_lost", lock_lost, 1'b1);
        chk("drop_losscnt", loss_cnt, LOSS_EN ? 8'd1 : 8'd0);
        step(); clr_lost = 1'b1; #1;
        step(); clr_lost = 1'b0; #1;
        chk("clr_lost", lock_lost, 1'b0);

        // Relock at 305 with a one-cycle glitch at settle count 100 -> READY at 668
        step(); pll_lock = 1'b1; #1;
        while (cyc < 668) begin
            step();
            if (cyc == 408) pll_lock = 1'b0;
            if (cyc == 409) pll_lock = 1'b1;
            #1;
            if (cyc == 564) chk("glitch_nominal_ready", ready, 1'b0);
            if (cyc == 667) begin
                chk("glitch_ready_pre", ready, 1'b0);
                chk("glitch_lost_pre", lock_lost, 1'b0);
            end
        end
        chk("glitch_ready", ready, 1'b1);
        chk("glitch_ce", ce, 4'hA);
        chk("glitch_align", align, 1'b1);
        chk("glitch_lost", lock_lost, 1'b0);

        // Second loss with CLR_LOST on the loss cycle
        tick();
        step(); pll_lock = 1'b0; #1;
        tick();
        step(); clr_lost = 1'b1; #1;
        step(); clr_lost = 1'b0; #1;
        chk("loss2_lost", lock_lost, 1'b1);
        chk("loss2_ready", ready, 1'b0);
        chk("loss2_losscnt", loss_cnt, LOSS_EN ? 8'd2 : 8'd0);

        // Relock at 674 -> RUN at 933, then async reset mid-RUN
        step(); pll_lock = 1'b1; #1;
        while (cyc < 940) begin
            tick();
            if (cyc == 932) chk("relock_ready_pre", ready, 1'b0);
            if (cyc == 933) begin
                chk("relock_ready", ready, 1'b1);
                chk("relock_ce", ce, 4'hA);
            end
        end
        chk("prerst_ce", ce, 4'h3);
        arst_n = 1'b0;
        #1;
        chk("arst_ready", ready, 1'b0);
        chk("arst_ce", ce, 4'h0);
        chk("arst_align", align, 1'b0);
        chk("arst_lost", lock_lost, 1'b0);
        chk("arst_losscnt", loss_cnt, 8'h00);
        #1;
        arst_n = 1'b1;
        cyc = 0;
        while (cyc < 271) begin
            tick();
            if (cyc == 258) chk("rerun_ready_pre", ready, 1'b0);
            if (cyc == 259) begin
                chk("rerun_ready", ready, 1'b1);
                chk("rerun_ce", ce, 4'hF);
                chk("rerun_align", align, 1'b1);
            end
            if (cyc == 262) chk("rerun_ce_gap", ce, 4'h0);
            if (cyc == 271) begin
                chk("rerun_ce_period", ce, 4'hF);
                chk("rerun_align_period", align, 1'b1);
            end
        end

        // Short-settle instance: 300 loss events, counter saturation
        for (int i = 1; i <= 300; i++) begin
            step(); pll2 = 1'b1; #1;
            n = 0;
            while (ready2 !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("d2_ready", ready2, 1'b1);
            if (i == 1) chk("d2_latency", n, 5);
            pll2 = 1'b0;
            tick();
            tick();
            tick();
            if (i == 1) begin
                chk("d2_ready_drop", ready2, 1'b0);
                chk("d2_lost", lost2, 1'b1);
            end
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
                chk("d2_losscnt", loss_cnt2, LOSS_EN ? ((i > 255) ? 255 : i) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccc_clken_gen.md
Name: ccc_clken_gen

Overview:
- Parametrised multi-channel clock-enable generator; successor to the single-output fixed-divide CCC wrapper.
- Runs on the CCC fabric output clock and qualifies all outputs with PLL lock.
- Produces per-channel one-cycle clock enables with runtime-programmable divide and phase, so downstream logic (e.g. blinker timebases) avoids extra PLL outputs.
- Adds a lock-settle sequencer, lock-loss reporting and an all-channel alignment marker.

Parameters:
- NUM_CH, 4, number of enable channels (1..8).
- DIV_W, 7, width of each divide and phase field.
- DIV_DEFAULT, 12, reset value of every channel's divide shadow register.
- PHASE_DEFAULT, 0, reset value of every channel's phase shadow register.
- LOCK_SETTLE, 256, consecutive synchronised-lock cycles required before RUN (>=1).

Ports:
- CLK  in  1  fabric clock (CCC OUT0_FABCLK).
- ARST_N  in  1  asynchronous active-low reset.
- PLL_LOCK  in  1  raw PLL lock, asynchronous to CLK.
- CFG_LOAD  in  1  one-cycle strobe; captures DIV_VAL and PHASE_VAL.
- DIV_VAL  in  NUM_CH*DIV_W  per-channel divide; channel i at [i*DIV_W +: DIV_W].
- PHASE_VAL  in  NUM_CH*DIV_W  per-channel phase offset, same packing.
- CLR_LOST  in  1  clears LOCK_LOST.
- CE  out  NUM_CH  per-channel clock enables.
- ALIGN  out  1  all active channels at count 0.
- READY  out  1  high in RUN.
- LOCK_LOST  out  1  sticky lock-loss-in-RUN flag.
- LOSS_CNT  out  8  lock-loss event count (see Optional Feature).

Behaviour:
- Reset (ARST_N low): CE=0, ALIGN=0, READY=0, LOCK_LOST=0, LOSS_CNT=0, state WAIT_LOCK, all counters 0, shadows = DIV_DEFAULT/PHASE_DEFAULT. Reset deassertion is used directly; no internal reset sync.
- PLL_LOCK passes through a 2-flop synchroniser, reset to 0. lk = synchronised lock.
- WAIT_LOCK:
  - settle counter held at 0.
  - lk=1 -> SETTLE.
- SETTLE:
  - settle counter increments each cycle with lk=1.
  - lk=0 -> WAIT_LOCK, counter cleared.
  - Counter reaching LOCK_SETTLE-1 with lk=1 -> RUN.
  - Minimum raw-lock-to-READY latency: 2 + 1 + LOCK_SETTLE cycles.
- RUN:
  - READY=1.
  - lk=0 -> WAIT_LOCK next cycle; CE, ALIGN and READY all 0 from that cycle.
  - Set LOCK_LOST; increment LOSS_CNT when enabled.
- Channel counters:
  - On RUN entry and on every applied CFG_LOAD, each cnt[i] is set to 0.
  - Each RUN cycle cnt[i] advances: cnt[i]+1, wrapping to 0 after D-1, where D = divide shadow.
  - Effective phase P = phase shadow if P < D, else 0.
  - CE[i] is combinationally (cnt[i]==P) && RUN && D>=2.
  - D=1: CE[i] constant 1 in RUN.
  - D=0: channel disabled, CE[i]=0, channel ignored by ALIGN.
  - The first RUN cycle is count 0, so the first CE[i] fires on RUN-cycle P. Period = D cycles.
- CFG_LOAD:
  - Shadows capture in any state.
  - In RUN, all counters restart at 0 on the cycle after the strobe.
  - No CE is emitted on the strobe cycle itself; CE resumes with the new D/P from that restart.
  - CFG_LOAD coincident with lock loss: shadows captured, lock loss wins, new values used on the next RUN.
- ALIGN: 1 in RUN when every channel with D>=1 has cnt==0. If all channels are disabled, ALIGN=0.
- LOCK_LOST:
  - Set only on a RUN->WAIT_LOCK transition.
  - CLR_LOST clears it.
  - Simultaneous set and clear: set wins.
  - Not set by glitches during SETTLE.
- LOSS_CNT saturates at 255; it is cleared only by reset.

Optional Feature:
- Macro CCC_CLKEN_LOSS_CNT_EN.
- Defined: LOSS_CNT is an 8-bit saturating counter as above.
- Undefined: the LOSS_CNT port remains but is tied to 8'h00, and no counter registers are inferred.
- All other behaviour is identical either way.

Test Plan:
- Reset, raw lock asserted at cycle 10, LOCK_SETTLE=256, defaults -> READY rises at cycle 269; CE[0..3] first pulse that cycle; then every 12 cycles; ALIGN coincident.
- Channel 0 DIV=5/PHASE=2, channel 1 DIV=1, channel 2 DIV=0, channel 3 DIV=3/PHASE=7 via CFG_LOAD in RUN:
  - CE[0] at restart+2, +7, +12, …
  - CE[1] constant high.
  - CE[2] low.
  - CE[3] at restart+0, +3, … (phase clamped).
  - ALIGN every 15 cycles.
- Lock dropped for 1 raw cycle during SETTLE at count 100 -> return to WAIT_LOCK; READY delayed a full LOCK_SETTLE; LOCK_LOST stays 0.
- Lock dropped in RUN:
  - CE/READY low 3 cycles after the raw drop.
  - LOCK_LOST=1, LOSS_CNT=1 (macro on) or 0 (macro off).
  - CLR_LOST on the same cycle as a second loss leaves LOCK_LOST=1.
- 300 loss events with macro on -> LOSS_CNT holds 255.
- ARST_N pulsed low mid-RUN -> all outputs 0 immediately; shadows revert to 12/0.
